reduce_tree_pipe: RTL and testbench

- Parametrised, pipelined N-input logic reduction unit; next generation of the team's fixed 4-input OR gate.
- Builds a radix-4 reduction tree with one register level per tree level. Supports runtime-selectable OR/AND/XOR/NOR with a valid/ready handshake.
- Used by datapath blocks (zero-detect, parity, flag merge) that need wide reductions without long combinational paths.

---
 rtl/reduce_pkg.sv | 45 ++++
 rtl/reduce4_stage.sv | 81 ++++++++
 rtl/reduce_tree_pipe.sv | 69 ++++++
 tb/tb_reduce_tree_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined reduction tree.
// Provides the mode encodings, the level-count and per-level width helpers,
// and the pad value a partial group uses so it never disturbs a node result.
package reduce_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OR  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_AND = 2'b01;
    localparam logic [MODE_W-1:0] MODE_XOR = 2'b10;
    localparam logic [MODE_W-1:0] MODE_NOR = 2'b11;

    // Number of radix-4 levels needed to reduce n bits to one (n in 2..256).
    function automatic int unsigned clog4(input int unsigned n);
        int unsigned lv;
        int unsigned cap;
        lv  = 0;
        cap = 1;
        for (int i = 0; i < 5; i++) begin
            if (cap < n) begin
                cap = cap * 4;
                lv  = lv + 1;
            end
        end
        return lv;
    endfunction

    // Node count after k levels of radix-4 reduction: ceil(n / 4^k).
    function automatic int unsigned level_w(input int unsigned n, input int unsigned k);
        int unsigned w;
        w = n;
        for (int unsigned i = 0; i < 5; i++) begin
            if (i < k) begin
                w = (w + 3) / 4;
            end
        end
        return w;
    endfunction

    // Identity element of the operator used by a mode.
    function automatic logic identity(input logic [MODE_W-1:0] mode);
        return (mode == MODE_AND);
    endfunction

endpackage

// File: rtl/reduce4_stage.sv
// One register level of the reduction tree.
// Ports: clk/rst (async active-high), en (global advance), in_data/in_mode/
// in_valid from the previous level, out_data/out_mode/out_valid registered.
// Groups inputs by four, pads a partial last group with the operator identity,
// and applies the NOR inversion only on the final level.
module reduce4_stage
    import reduce_pkg::*;
#(
    parameter int unsigned W_IN    = 4,
    parameter bit          IS_LAST = 1'b0,
    localparam int unsigned W_OUT  = (W_IN + 3) / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [W_IN-1:0]   in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic              in_valid,
    output logic [W_OUT-1:0]  out_data,
    output logic [MODE_W-1:0] out_mode,
    output logic              out_valid
);

    localparam int unsigned W_PAD = 4 * W_OUT;

    logic [W_PAD-1:0]  padded;
    logic [3:0]        grp;
    logic [W_OUT-1:0]  node_res;

    logic [W_OUT-1:0]  data_d,  data_q;
    logic [MODE_W-1:0] mode_d,  mode_q;
    logic              valid_d, valid_q;

    // Padded radix-4 nodes; OR and NOR share the OR operator.
    always_comb begin
        padded            = {W_PAD{identity(in_mode)}};
        padded[W_IN-1:0]  = in_data;
        grp               = '0;
        node_res          = '0;
        for (int n = 0; n < int'(W_OUT); n++) begin
            grp = padded[4*n +: 4];
            case (in_mode)
                MODE_AND: node_res[n] = &grp;
                MODE_XOR: node_res[n] = ^grp;
                default:  node_res[n] = |grp;
            endcase
            if (IS_LAST && (in_mode == MODE_NOR)) begin
                node_res[n] = ~node_res[n];
            end
        end
    end

    // Load on advance regardless of valid; hold otherwise.
    always_comb begin
        data_d  = data_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        if (en) begin
            data_d  = node_res;
            mode_d  = in_mode;
            valid_d = in_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            mode_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_mode  = mode_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N_IN-input OR/AND/XOR/NOR reduction with valid/ready handshake.
// Ports: clk, rst (async active-high); in_data/in_mode/in_valid/in_ready on
// the input side; out_result/out_mode/out_valid/out_ready on the output side.
// One register level per radix-4 tree level; a single global advance stalls
// every stage together, so bubbles are kept and order is preserved.
module reduce_tree_pipe
    import reduce_pkg::*;
#(
    parameter int unsigned N_IN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_result,
    output logic [MODE_W-1:0] out_mode,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned LEVELS = clog4(N_IN);

    logic              advance_c;
    logic [MODE_W-1:0] mode_s  [0:LEVELS];
    logic              valid_s [0:LEVELS];

    // Pipeline moves whenever the output slot is empty or being drained.
    assign advance_c  = out_ready | ~out_valid;
    assign in_ready   = advance_c;

    assign mode_s[0]  = in_mode;
    assign valid_s[0] = in_valid;

    for (genvar k = 0; k < int'(LEVELS); k++) begin : g_lvl
        localparam int unsigned W_I = level_w(N_IN, k);
        localparam int unsigned W_O = level_w(N_IN, k + 1);

        logic [W_I-1:0] lvl_in;
        logic [W_O-1:0] lvl_out;

        if (k == 0) begin : g_first
            assign lvl_in = in_data;
        end else begin : g_next
            assign lvl_in = g_lvl[k-1].lvl_out;
        end

        reduce4_stage #(
            .W_IN    (W_I),
            .IS_LAST (k == int'(LEVELS) - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance_c),
            .in_data   (lvl_in),
            .in_mode   (mode_s[k]),
            .in_valid  (valid_s[k]),
            .out_data  (lvl_out),
            .out_mode  (mode_s[k+1]),
            .out_valid (valid_s[k+1])
        );
    end

    assign out_result = g_lvl[LEVELS-1].lvl_out[0];
    assign out_mode   = mode_s[LEVELS];
    assign out_valid  = valid_s[LEVELS];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed bench for reduce_tree_pipe at N_IN = 16, 10, 2 and 17.
module tb_reduce_tree_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N_IN = 16 (LEVELS 2)
    logic [15:0] d16_data;  logic [1:0] d16_mode;  logic d16_valid, d16_in_ready;
    logic d16_res;  logic [1:0] d16_omode;  logic d16_ovalid, d16_oready;
    // N_IN = 10 (LEVELS 2)
    logic [9:0]  d10_data;  logic [1:0] d10_mode;  logic d10_valid, d10_in_ready;
    logic d10_res;  logic [1:0] d10_omode;  logic d10_ovalid, d10_oready;
    // N_IN = 2 (LEVELS 1)
    logic [1:0]  d2_data;   logic [1:0] d2_mode;   logic d2_valid, d2_in_ready;
    logic d2_res;   logic [1:0] d2_omode;   logic d2_ovalid, d2_oready;
    // N_IN = 17 (LEVELS 3)
    logic [16:0] d17_data;  logic [1:0] d17_mode;  logic d17_valid, d17_in_ready;
    logic d17_res;  logic [1:0] d17_omode;  logic d17_ovalid, d17_oready;

    reduce_tree_pipe #(.N_IN(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_data(d16_data), .in_mode(d16_mode),
        .in_valid(d16_valid), .in_ready(d16_in_ready), .out_result(d16_res),
        .out_mode(d16_omode), .out_valid(d16_ovalid), .out_ready(d16_oready));
    reduce_tree_pipe #(.N_IN(10)) u_dut10 (
        .clk(clk), .rst(rst), .in_data(d10_data), .in_mode(d10_mode),
        .in_valid(d10_valid), .in_ready(d10_in_ready), .out_result(d10_res),
        .out_mode(d10_omode), .out_valid(d10_ovalid), .out_ready(d10_oready));
    reduce_tree_pipe #(.N_IN(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(d2_data), .in_mode(d2_mode),
        .in_valid(d2_valid), .in_ready(d2_in_ready), .out_result(d2_res),
        .out_mode(d2_omode), .out_valid(d2_ovalid), .out_ready(d2_oready));
    reduce_tree_pipe #(.N_IN(17)) u_dut17 (
        .clk(clk), .rst(rst), .in_data(d17_data), .in_mode(d17_mode),
        .in_valid(d17_valid), .in_ready(d17_in_ready), .out_result(d17_res),
        .out_mode(d17_omode), .out_valid(d17_ovalid), .out_ready(d17_oready));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DUT select: 0 -> N16, 1 -> N10, 2 -> N2, 3 -> N17
    task automatic set_in(input int d, input logic v, input logic [16:0] data, input logic [1:0] m);
        case (d)
            0: begin d16_valid = v; d16_data = data[15:0]; d16_mode = m; end
            1: begin d10_valid = v; d10_data = data[9:0];  d10_mode = m; end
            2: begin d2_valid  = v; d2_data  = data[1:0];  d2_mode  = m; end
            default: begin d17_valid = v; d17_data = data; d17_mode = m; end
        endcase
    endtask

    // Packed {in_ready, out_valid, out_mode, out_result} of the selected DUT.
    function automatic logic [4:0] outs(input int d);
        case (d)
            0: return {d16_in_ready, d16_ovalid, d16_omode, d16_res};
            1: return {d10_in_ready, d10_ovalid, d10_omode, d10_res};
            2: return {d2_in_ready,  d2_ovalid,  d2_omode,  d2_res};
            default: return {d17_in_ready, d17_ovalid, d17_omode, d17_res};
        endcase
    endfunction

    // Single transfer; checks out_valid stays low until exactly lat edges later.
    task automatic one_shot(input string tag, input int d, input logic [16:0] data,
                            input logic [1:0] m, input logic exp, input int lat);
        logic [4:0] o;
        set_in(d, 1'b1, data, m);
        o = outs(d);
        check({tag, "_in_ready"}, 32'(o[4]), 32'd1);
        @(posedge clk); #1;
        set_in(d, 1'b0, 17'd0, 2'd0);
        for (int c = 1; c < lat; c++) begin
            o = outs(d);
            check({tag, "_early_valid"}, 32'(o[3]), 32'd0);
            @(posedge clk); #1;
        end
        o = outs(d);
        check({tag, "_valid"},  32'(o[3]),   32'd1);
        check({tag, "_result"}, 32'(o[0]),   32'(exp));
        check({tag, "_mode"},   32'(o[2:1]), 32'(m));
        @(posedge clk); #1;
        o = outs(d);
        check({tag, "_drain"},  32'(o[3]),   32'd0);
    endtask

    logic [15:0] vec_data [0:4];
    logic [1:0]  vec_mode [0:4];
    logic        vec_exp  [0:4];

    // Back-to-back stream on the N16 unit with out_ready held high.
    task automatic stream16(input string tag, input int n);
        for (int i = 0; i <= n; i++) begin
            if (i < n) set_in(0, 1'b1, {1'b0, vec_data[i]}, vec_mode[i]);
            else       set_in(0, 1'b0, 17'd0, 2'd0);
            @(posedge clk); #1;
            if (i == 0) begin
                check({tag, "_lat_valid"}, 32'(d16_ovalid), 32'd0);
            end else begin
                check({tag, "_valid"},  32'(d16_ovalid), 32'd1);
                check({tag, "_result"}, 32'(d16_res),    32'(vec_exp[i-1]));
                check({tag, "_mode"},   32'(d16_omode),  32'(vec_mode[i-1]));
            end
        end
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'(d16_ovalid), 32'd0);
    endtask

    task automatic load_vec(input int i, input logic [15:0] dat, input logic [1:0] m, input logic e);
        vec_data[i] = dat; vec_mode[i] = m; vec_exp[i] = e;
    endtask

    initial begin
        int sent, recv, stall_left;
        logic acc, cons, held_r;
        logic [1:0] held_m;

        rst = 1'b1;
        d16_oready = 1'b1; d10_oready = 1'b1; d2_oready = 1'b1; d17_oready = 1'b1;
        for (int d = 0; d < 4; d++) set_in(d, 1'b0, 17'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  32'(d16_ovalid), 32'd0);
        check("rst_result", 32'(d16_res),    32'd0);
        check("rst_mode",   32'(d16_omode),  32'd0);
        check("rst_valid17", 32'(d17_ovalid), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(d16_in_ready), 32'd1);

        // Test 1: OR/AND stream, results 0,1,1,0
        load_vec(0, 16'h0000, 2'b00, 1'b0);
        load_vec(1, 16'h0100, 2'b00, 1'b1);
        load_vec(2, 16'hFFFF, 2'b01, 1'b1);
        load_vec(3, 16'hFFFE, 2'b01, 1'b0);
        stream16("t1", 4);

        // Test 2: XOR/NOR stream, results 0,1,1,0
        load_vec(0, 16'h8001, 2'b10, 1'b0);
        load_vec(1, 16'h8003, 2'b10, 1'b1);
        load_vec(2, 16'h0000, 2'b11, 1'b1);
        load_vec(3, 16'h0010, 2'b11, 1'b0);
        stream16("t2", 4);

        // Test 3: N_IN=10 padding
        one_shot("t3_and_ones", 1, 17'h003FF, 2'b01, 1'b1, 2);
        one_shot("t3_and_zero", 1, 17'h003FE, 2'b01, 1'b0, 2);
        one_shot("t3_or_msb",   1, 17'h00200, 2'b00, 1'b1, 2);
        one_shot("t3_nor_zero", 1, 17'h00000, 2'b11, 1'b1, 2);

        // Test 4: backpressure, 3-cycle stall after first out_valid
        load_vec(0, 16'h0001, 2'b00, 1'b1);
        load_vec(1, 16'hFFFF, 2'b01, 1'b1);
        load_vec(2, 16'h0007, 2'b10, 1'b1);
        load_vec(3, 16'h0003, 2'b10, 1'b0);
        load_vec(4, 16'h0000, 2'b11, 1'b1);
        sent = 0; recv = 0; stall_left = 3; held_r = 1'b0; held_m = 2'b00;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            if (sent < 5) set_in(0, 1'b1, {1'b0, vec_data[sent]}, vec_mode[sent]);
            else          set_in(0, 1'b0, 17'd0, 2'd0);
            if (d16_ovalid && stall_left > 0) begin
                d16_oready = 1'b0;
                if (stall_left == 3) begin
                    held_r = d16_res;
                    held_m = d16_omode;
                end else begin
                    check("bp_hold_valid",  32'(d16_ovalid), 32'd1);
                    check("bp_hold_result", 32'(d16_res),    32'(held_r));
                    check("bp_hold_mode",   32'(d16_omode),  32'(held_m));
                end
                stall_left--;
            end else begin
                d16_oready = 1'b1;
            end
            #1;
            if (!d16_oready) check("bp_in_ready", 32'(d16_in_ready), 32'd0);
            acc  = d16_valid & d16_in_ready;
            cons = d16_ovalid & d16_oready;
            if (cons) begin
                check("bp_result", 32'(d16_res),   32'(vec_exp[recv]));
                check("bp_mode",   32'(d16_omode), 32'(vec_mode[recv]));
                recv++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        d16_oready = 1'b1;
        set_in(0, 1'b0, 17'd0, 2'd0);
        check("bp_sent", 32'(sent), 32'd5);
        check("bp_recv", 32'(recv), 32'd5);
        @(posedge clk); #1;
        check("bp_idle", 32'(d16_ovalid), 32'd0);

        // Test 5: async reset with two results in flight
        set_in(0, 1'b1, 17'h0FFFF, 2'b01);
        @(posedge clk); #1;
        set_in(0, 1'b1, 17'h00003, 2'b10);
        @(posedge clk); #1;
        set_in(0, 1'b0, 17'd0, 2'd0);
        check("rm_pre_valid", 32'(d16_ovalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rm_valid",  32'(d16_ovalid), 32'd0);
        check("rm_result", 32'(d16_res),    32'd0);
        check("rm_mode",   32'(d16_omode),  32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("rm_stale", 32'(d16_ovalid), 32'd0);
        end
        one_shot("rm_fresh", 0, 17'h00001, 2'b10, 1'b1, 2);

        // Test 6: N_IN=2 and N_IN=17
        one_shot("t6_n2_xor",   2, 17'h00002, 2'b10, 1'b1, 1);
        one_shot("t6_n2_and",   2, 17'h00002, 2'b01, 1'b0, 1);
        one_shot("t6_n17_or",   3, 17'h10000, 2'b00, 1'b1, 3);
        one_shot("t6_n17_and",  3, 17'h1FFFF, 2'b01, 1'b1, 3);
        one_shot("t6_n17_nor",  3, 17'h10000, 2'b11, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
